// File: rtl/uart_cfg.sv
// uart_cfg: UART transmitter with a TX FIFO and a receiver with sticky error flags.
// Both directions share one 16x oversampling tick derived from the clock.
module uart_cfg #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_full,
    input  logic                 rx,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic ODD = PARITY == 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DW-1:0] div_cnt;
    logic          tick16;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick16  <= 1'b0;
        end else begin
            div_cnt <= div_cnt == DW'(DIV - 1) ? '0 : div_cnt + 1'b1;
            tick16  <= div_cnt == DW'(DIV - 1);
        end
    end

    logic [DATA_BITS-1:0] mem [TX_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop;

    assign tx_full = count == CW'(TX_DEPTH);
    assign push    = wr_en && !tx_full;

    always_ff @(posedge clk_50m) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    state_t               tx_state;
    logic [3:0]           tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic                 tx_snum;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_last_stop;

    assign tx_last_stop = tx_snum == 1'(STOP_BITS - 1);
    // A word is popped either from idle or straight out of the final stop bit, so frames run back-to-back.
    assign pop = count != '0 && tick16 &&
                 (tx_state == S_IDLE || (tx_state == S_STOP && tx_cnt == 4'd15 && tx_last_stop));
    assign tx_busy = count != '0 || tx_state != S_IDLE;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_snum  <= 1'b0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else if (pop) begin
            tx_state <= S_START;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_sh    <= mem[rd_ptr];
            tx_par   <= ^mem[rd_ptr] ^ ODD;
        end else if (tick16 && tx_state != S_IDLE) begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_cnt == 4'd15) begin
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx       <= tx_sh[0];
                        tx_idx   <= '0;
                    end
                    S_DATA: begin
                        tx_snum <= 1'b0;
                        if (tx_idx == BW'(DATA_BITS - 1)) begin
                            tx_state <= PARITY != 0 ? S_PARITY : S_STOP;
                            tx       <= PARITY != 0 ? tx_par : 1'b1;
                        end else begin
                            tx_sh  <= tx_sh >> 1;
                            tx     <= tx_sh[1];
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx       <= 1'b1;
                    end
                    default: begin
                        if (tx_last_stop)
                            tx_state <= S_IDLE;
                        else
                            tx_snum <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic                 rx_s1, rx_s2, rx_prev;
    state_t               rx_state;
    logic [4:0]           rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_pbad;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_pbad    <= 1'b0;
            rdy        <= 1'b0;
            dout       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rdy_clr) begin
                rdy        <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (rx_state == S_IDLE) begin
                if (rx_prev && !rx_s2) begin
                    rx_state <= S_START;
                    rx_cnt   <= '0;
                end
            end else if (tick16) begin
                rx_cnt <= rx_cnt + 1'b1;
                case (rx_state)
                    S_START: begin
                        if (rx_cnt == 5'd7) begin
                            rx_state <= rx_s2 ? S_IDLE : S_DATA;
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (rx_cnt == 5'd15) begin
                            rx_cnt  <= '0;
                            rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                            rx_idx  <= rx_idx + 1'b1;
                            rx_pbad <= 1'b0;
                            if (rx_idx == BW'(DATA_BITS - 1))
                                rx_state <= PARITY != 0 ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        if (rx_cnt == 5'd15) begin
                            rx_cnt   <= '0;
                            rx_state <= S_STOP;
                            rx_pbad  <= rx_s2 != (^rx_sh ^ ODD);
                        end
                    end
                    default: begin
                        // An acknowledge in the same cycle frees the holding register for the new word.
                        if (rx_cnt == 5'd15) begin
                            if (rdy && !rdy_clr)
                                overrun <= 1'b1;
                            else begin
                                dout <= rx_sh;
                                rdy  <= 1'b1;
                            end
                            if (rx_pbad)
                                parity_err <= 1'b1;
                            if (!rx_s2)
                                frame_err <= 1'b1;
                        end else if (rx_cnt == 5'd16)
                            rx_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: randomized loopback bench for uart_cfg with a cycle-level line model
// for the 8N1 instance and directed frames for the 7E1 instance.
module tb_uart_cfg;
    localparam int DB = 8;
    localparam int PAR = 0;
    localparam int SB = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din_a = '0;
    logic       wr_en_a = 1'b0, loop_a = 1'b1, rx_a_drv = 1'b1;
    logic       auto_ack = 1'b0, ack_auto = 1'b0, ack_man = 1'b0;
    logic       tx_a, tx_busy_a, tx_full_a, rdy_a, frame_err_a, parity_err_a, overrun_a;
    logic [7:0] dout_a;

    logic [6:0] din_b = '0;
    logic       wr_en_b = 1'b0, loop_b = 1'b1, rx_b_drv = 1'b1, rdy_clr_b = 1'b0;
    logic       tx_b, tx_busy_b, tx_full_b, rdy_b, frame_err_b, parity_err_b, overrun_b;
    logic [6:0] dout_b;

    uart_cfg #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(DB), .PARITY(PAR),
               .STOP_BITS(SB), .TX_DEPTH(DEPTH)) dut_a (
        .clk_50m(clk), .rst_n(rst_n), .din(din_a), .wr_en(wr_en_a), .tx(tx_a),
        .tx_busy(tx_busy_a), .tx_full(tx_full_a), .rx(loop_a ? tx_a : rx_a_drv),
        .rdy(rdy_a), .rdy_clr(ack_auto | ack_man), .dout(dout_a),
        .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a));

    uart_cfg #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
               .STOP_BITS(1), .TX_DEPTH(16)) dut_b (
        .clk_50m(clk), .rst_n(rst_n), .din(din_b), .wr_en(wr_en_b), .tx(tx_b),
        .tx_busy(tx_busy_b), .tx_full(tx_full_b), .rx(loop_b ? tx_b : rx_b_drv),
        .rdy(rdy_b), .rdy_clr(rdy_clr_b), .dout(dout_b),
        .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b));

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: accepted words queue up, and the line plays each as 16-cycle levels back-to-back.
    logic [7:0] mq[$];
    logic [7:0] rxq[$];
    logic       lq[$];
    logic       m_line = 1'b1, m_busy = 1'b0, prev_rdy = 1'b0, acc;
    logic [7:0] w;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete(); lq.delete(); rxq.delete();
            m_line = 1'b1; m_busy = 1'b0; prev_rdy = 1'b0;
            chk("rst_out", {tx_a, tx_busy_a, tx_full_a, rdy_a, frame_err_a, parity_err_a, overrun_a}, 7'b1000000);
            chk("rst_dout", dout_a, 0);
        end else begin
            chk("tx_line", tx_a, m_line);
            chk("tx_busy", tx_busy_a, m_busy || mq.size() != 0);
            chk("tx_full", tx_full_a, mq.size() == DEPTH);
            if (loop_a && rdy_a && !prev_rdy) begin
                chk("rx_avail", rxq.size() != 0, 1);
                if (rxq.size() != 0)
                    chk("rx_word", dout_a, rxq.pop_front());
                chk("rx_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
            end
            prev_rdy = rdy_a;
            acc = wr_en_a && mq.size() < DEPTH;
            if (lq.size() == 0 && mq.size() != 0) begin
                w = mq.pop_front();
                rxq.push_back(w);
                repeat (16) lq.push_back(1'b0);
                for (int b = 0; b < DB; b++) repeat (16) lq.push_back(w[b]);
                if (PAR != 0) repeat (16) lq.push_back(^w ^ (PAR == 1));
                repeat (16 * SB) lq.push_back(1'b1);
            end
            m_busy = lq.size() != 0;
            m_line = lq.size() != 0 ? lq.pop_front() : 1'b1;
            if (acc)
                mq.push_back(din_a);
        end
    end

    always @(posedge clk) begin
        #1 ack_auto = auto_ack && rdy_a;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        din_a = d; wr_en_a = 1'b1;
        cyc(1);
        wr_en_a = 1'b0;
    endtask

    task automatic drive(input logic v, input logic sel);
        if (sel) rx_b_drv = v; else rx_a_drv = v;
        cyc(16);
    endtask

    task automatic send_rx(input logic [8:0] d, input int nb, input int par, input logic stop, input logic sel);
        drive(1'b0, sel);
        for (int i = 0; i < nb; i++) drive(d[i], sel);
        if (par >= 0) drive(par[0], sel);
        drive(stop, sel);
        if (sel) rx_b_drv = 1'b1; else rx_a_drv = 1'b1;
    endtask

    int ea[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int eb[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [7:0] bw[5] = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h55};

    initial begin
        #1 rst_n = 1'b0;
        cyc(4);
        chk("init_tx", tx_a, 1);
        chk("init_flags", {tx_busy_a, tx_full_a, rdy_a, frame_err_a, parity_err_a, overrun_a}, 0);
        rst_n = 1'b1;
        cyc(3);

        wr(8'hA5);
        for (int i = 0; i < 50 && tx_a; i++) cyc(1);
        chk("a5_start_seen", tx_a, 0);
        cyc(8);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), tx_a, ea[k]);
            cyc(16);
        end
        for (int i = 0; i < 400 && !rdy_a; i++) cyc(1);
        chk("a5_rdy", rdy_a, 1);
        chk("a5_dout", dout_a, 8'hA5);
        chk("a5_flags", {frame_err_a, parity_err_a, overrun_a}, 0);
        ack_man = 1'b1; cyc(1); ack_man = 1'b0;
        chk("a5_ack", rdy_a, 0);

        din_b = 7'h41; wr_en_b = 1'b1; cyc(1); wr_en_b = 1'b0;
        for (int i = 0; i < 50 && tx_b; i++) cyc(1);
        chk("b_start_seen", tx_b, 0);
        cyc(8);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("b41_bit%0d", k), tx_b, eb[k]);
            cyc(16);
        end
        for (int i = 0; i < 400 && !rdy_b; i++) cyc(1);
        chk("b_rdy", rdy_b, 1);
        chk("b_dout", dout_b, 7'h41);
        chk("b_flags", {frame_err_b, parity_err_b, overrun_b}, 0);
        rdy_clr_b = 1'b1; cyc(1); rdy_clr_b = 1'b0;
        loop_b = 1'b0;
        send_rx(9'h041, 7, 1, 1'b1, 1'b1);
        cyc(2);
        chk("b_perr", parity_err_b, 1);
        chk("b_perr_dout", dout_b, 7'h41);
        chk("b_perr_rdy_fe", {rdy_b, frame_err_b}, 2'b10);

        auto_ack = 1'b1;
        wr(8'h3C);
        cyc(20);
        wr_en_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din_a = bw[k];
            cyc(1);
            if (k == 2) chk("full_after3", tx_full_a, 0);
            if (k >= 3) chk($sformatf("full_after%0d", k + 1), tx_full_a, 1);
        end
        wr_en_a = 1'b0;
        for (int i = 0; i < 3000 && (tx_busy_a || rxq.size() != 0); i++) cyc(1);
        chk("burst_drain", rxq.size(), 0);
        chk("burst_last", dout_a, 8'hC4);

        for (int it = 0; it < 12; it++) begin
            cyc($urandom_range(0, 200));
            wr_en_a = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                din_a = 8'($urandom);
                cyc(1);
            end
            wr_en_a = 1'b0;
        end
        for (int i = 0; i < 8000 && (tx_busy_a || rxq.size() != 0); i++) cyc(1);
        chk("rand_drain", rxq.size(), 0);
        chk("rand_idle", tx_busy_a, 0);

        auto_ack = 1'b0;
        cyc(5);
        wr(8'h6E);
        wr(8'h91);
        for (int i = 0; i < 800 && !overrun_a; i++) cyc(1);
        chk("ovr_flag", overrun_a, 1);
        chk("ovr_dout", dout_a, 8'h6E);
        chk("ovr_rdy", rdy_a, 1);
        for (int i = 0; i < 400 && tx_busy_a; i++) cyc(1);
        rxq.delete();
        ack_man = 1'b1; cyc(1); ack_man = 1'b0;
        chk("ovr_clr", {rdy_a, overrun_a}, 0);

        loop_a = 1'b0;
        cyc(4);
        rx_a_drv = 1'b0; cyc(4); rx_a_drv = 1'b1;
        cyc(300);
        chk("false_start", {rdy_a, frame_err_a, parity_err_a, overrun_a}, 0);
        send_rx(9'h05A, 8, -1, 1'b0, 1'b0);
        cyc(2);
        chk("ferr_flag", frame_err_a, 1);
        chk("ferr_dout", dout_a, 8'h5A);
        chk("ferr_rdy_pe_ov", {rdy_a, parity_err_a, overrun_a}, 3'b100);
        ack_man = 1'b1; cyc(1); ack_man = 1'b0;
        chk("ferr_clr", frame_err_a, 0);
        cyc(40);
        loop_a = 1'b1;
        cyc(4);

        wr(8'hC3);
        wr(8'h11);
        wr(8'h22);
        cyc(55);
        chk("pre_rst_tx", tx_a, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_now", tx_a, 1);
        chk("rst_now_flags", {tx_busy_a, tx_full_a, rdy_a, frame_err_a, parity_err_a, overrun_a}, 0);
        chk("rst_now_dout", dout_a, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(400);
        chk("post_rst_idle", {tx_a, tx_busy_a, rdy_a}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
